// File: rtl/chan_sel_mux.sv
// Registered N-channel, W-bit selector with strobe-latched manual select.
// Define CHAN_SEL_MUX_SCAN_EN to add the auto-scan mode (dwell counter, hold, wrap).
module chan_sel_mux #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] i,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      load,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          o,
    output logic                      o_valid,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      wrap
);

    localparam logic [SEL_W:0]   CH_L = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS-1);

    logic [CHANNELS-1:0][WIDTH-1:0] chans;
    logic [SEL_W-1:0]               nsel;
    logic                           sel_ok;

    assign chans  = i;
    // Out-of-range strobes are dropped entirely.
    assign sel_ok = load && ({1'b0, sel} < CH_L);

`ifdef CHAN_SEL_MUX_SCAN_EN
    typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

    localparam int             CNT_W = $clog2(DWELL+1);
    localparam logic [CNT_W-1:0] DLAST = CNT_W'(DWELL-1);

    state_t           state, nstate;
    logic [CNT_W-1:0] cnt, ncnt;
    logic             nwrap;

    always_comb begin
        nstate = mode ? SCAN : MANUAL;
        nsel   = cur_sel;
        ncnt   = cnt;
        nwrap  = 1'b0;
        if (sel_ok) begin
            nsel = sel;
            ncnt = '0;
        end else if (state == SCAN && !hold) begin
            if (cnt == DLAST) begin
                ncnt = '0;
                if (cur_sel == LAST) begin
                    nsel  = '0;
                    nwrap = 1'b1;
                end else begin
                    nsel = cur_sel + 1'b1;
                end
            end else begin
                ncnt = cnt + 1'b1;
            end
        end
        // Any mode change restarts the dwell from zero.
        if (nstate != state) ncnt = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= MANUAL;
            cnt   <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
            wrap  <= nwrap;
        end
    end
`else
    localparam int unused_dwell = DWELL;
    logic          unused_ctl;

    assign unused_ctl = ^{mode, hold};
    assign nsel       = sel_ok ? sel : cur_sel;
    assign wrap       = 1'b0;
`endif

    // o and cur_sel load from the same nsel so they never disagree.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o       <= '0;
            o_valid <= 1'b0;
            cur_sel <= '0;
        end else begin
            o       <= chans[nsel];
            o_valid <= 1'b1;
            cur_sel <= nsel;
        end
    end

endmodule
